// File: rtl/tqvp_vga_copper_pkg.sv
// tqvp_vga_copper_pkg: shared state encoding, display-list entry layout and CTRL address.
package tqvp_vga_copper_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FIRE = 2'd2, DONE = 2'd3} cop_state_e;
    localparam int LINE_LSB = 0;
    localparam int LINE_W = 10;
    localparam int REG_LSB = 16;
    localparam int REG_W = 6;
    localparam int DATA_LSB = 24;
    localparam int DATA_W = 8;
    localparam logic [3:0] COP_CTRL_ADDR = 4'd8;
endpackage

// File: rtl/tqvp_vga_copper_list.sv
// tqvp_vga_copper_list: display-list register file, one sync write port,
// combinational reads at ptr and at ptr+1 (look-ahead for back-to-back entries).
module tqvp_vga_copper_list
    import tqvp_vga_copper_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_idx,
    input  logic [31:0]   i_wr_data,
    input  logic [AW-1:0] i_rd_idx,
    input  logic [AW-1:0] i_nx_idx,
    output logic [31:0]   o_rd_data,
    output logic [31:0]   o_nx_data
);
    logic [31:0] r_mem [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];
    assign o_nx_data = r_mem[i_nx_idx];
endmodule

// File: rtl/tqvp_vga_copper.sv
// tqvp_vga_copper: raster-timed register sequencer sharing the VGA register
// write port with the CPU; the CPU always wins and the copper write waits.
module tqvp_vga_copper
    import tqvp_vga_copper_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  cpu_address,
    input  logic [31:0] cpu_data_in,
    input  logic [1:0]  cpu_data_write_n,
    input  logic        cop_write,
    input  logic [3:0]  cop_address,
    input  logic [31:0] cop_data_in,
    input  logic        frame_start,
    input  logic [9:0]  vga_y,
    input  logic        vga_blank,
    output logic [5:0]  reg_address,
    output logic [31:0] reg_data,
    output logic [1:0]  reg_write_n,
    output logic [7:0]  status,
    output logic        done_irq
);
    localparam int AW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
    localparam logic [3:0] MAX_CNT = 4'(ENTRIES);

    cop_state_e  r_state, w_state_nxt;
    logic [3:0]  r_ptr, w_ptr_nxt, w_ptr_inc, r_count, w_count_nxt;
    logic        r_enable, w_enable_nxt, r_done_irq;
    logic        w_ctrl_wr, w_entry_wr, w_cpu_idle, w_cop_wr, w_match, w_nx_match, w_last;
    logic [31:0] w_entry, w_nx_entry;
    logic        w_unused;

    tqvp_vga_copper_list #(.ENTRIES(ENTRIES), .AW(AW)) u_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_entry_wr),
        .i_wr_idx  (cop_address[AW-1:0]),
        .i_wr_data (cop_data_in),
        .i_rd_idx  (r_ptr[AW-1:0]),
        .i_nx_idx  (w_ptr_inc[AW-1:0]),
        .o_rd_data (w_entry),
        .o_nx_data (w_nx_entry)
    );

    assign w_ctrl_wr    = cop_write && cop_address == COP_CTRL_ADDR;
    assign w_entry_wr   = cop_write && cop_address < MAX_CNT;
    assign w_enable_nxt = w_ctrl_wr ? cop_data_in[0] : r_enable;
    assign w_count_nxt  = !w_ctrl_wr ? r_count : cop_data_in[7:4] > MAX_CNT ? MAX_CNT : cop_data_in[7:4];
    assign w_ptr_inc    = r_ptr + 4'd1;
    assign w_cpu_idle   = cpu_data_write_n == 2'b11;
    assign w_match      = vga_blank && vga_y == w_entry[LINE_LSB +: LINE_W];
    assign w_nx_match   = vga_blank && vga_y == w_nx_entry[LINE_LSB +: LINE_W];
    assign w_last       = w_ptr_inc == r_count;
    // frame_start and disable both preempt a pending write.
    assign w_cop_wr     = r_state == FIRE && w_cpu_idle && !frame_start && w_enable_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (frame_start) begin
            w_state_nxt = (w_enable_nxt && w_count_nxt != 4'd0) ? ARMED : IDLE;
            w_ptr_nxt   = '0;
        end else if (!w_enable_nxt) begin
            w_state_nxt = IDLE;
        end else if (r_state == ARMED && w_match) begin
            w_state_nxt = FIRE;
        end else if (w_cop_wr) begin
            w_ptr_nxt   = w_ptr_inc;
            w_state_nxt = w_last ? DONE : w_nx_match ? FIRE : ARMED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_enable   <= 1'b0;
            r_count    <= '0;
            r_done_irq <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_enable   <= w_enable_nxt;
            r_count    <= w_count_nxt;
            r_done_irq <= w_state_nxt == DONE && r_state != DONE;
        end
    end

    assign reg_address = w_cop_wr ? w_entry[REG_LSB +: REG_W] : cpu_address;
    assign reg_data    = w_cop_wr ? {24'd0, w_entry[DATA_LSB +: DATA_W]} : cpu_data_in;
    assign reg_write_n = w_cop_wr ? 2'b00 : cpu_data_write_n;
    assign status      = {r_state, 1'b0, r_ptr, r_enable};
    assign done_irq    = r_done_irq;
    assign w_unused    = ^{w_entry[15:10], w_entry[23:22], w_nx_entry[31:10]};
endmodule
